mm_arbiter: RTL and testbench

- Shares one P-384 Montgomery multiplier instance among NUM_REQ requesters, such as the point-add, point-double and inversion sequencers.
- Arbitrates round-robin and latches the winner's operands.
- Drives the multiplier's single-cycle start pulse, waits for multiplier completion, captures the product and returns it to the winner with a one-cycle response pulse.
- Runs a watchdog so a hung multiplier cannot deadlock the ECC core.

---
 rtl/mm_arbiter_pkg.sv | 21 ++
 rtl/mm_arbiter_rr.sv | 43 ++++
 rtl/mm_arbiter.sv | 156 +++++++++++++++
 tb/tb_mm_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_arbiter_pkg.sv
// Shared definitions for the Montgomery-multiplier arbiter: FSM encoding,
// P-384 operand width, default watchdog limit and grant-index sizing.
package mm_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int P384_REG_SIZE   = 384;
    localparam int DEFAULT_TIMEOUT = 63;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_arbiter_rr.sv
// Round-robin grant selection: picks the first asserted request at or above
// the pointer (wrapping) and advances the pointer past the winner on a grant.
module rr_arbiter
    import mm_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_grant_en,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_cand = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

    // Pointer moves to the requester just after the one granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_grant_en) begin
            r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mm_arbiter.sv
// Shares one P-384 Montgomery multiplier among NUM_REQ sequencers: round-robin
// accept, one-cycle start pulse, a blanking cycle while the multiplier's stale
// ready settles, bounded wait for completion, then a one-cycle response.
module mm_arbiter
    import mm_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int REG_SIZE = P384_REG_SIZE,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*REG_SIZE-1:0]  opa_i,
    input  logic [NUM_REQ*REG_SIZE-1:0]  opb_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic                         rsp_err_o,
    output logic [REG_SIZE-1:0]          res_o,
    output logic                         busy_o,
    output logic                         mm_start_o,
    output logic [REG_SIZE-1:0]          mm_opa_o,
    output logic [REG_SIZE-1:0]          mm_opb_o,
    input  logic [REG_SIZE-1:0]          mm_p_i,
    input  logic                         mm_ready_i
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_gnt;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_any;
    logic                w_grant_en;
    logic                w_wd_expired;
    logic [REG_SIZE-1:0] w_sel_opa;
    logic [REG_SIZE-1:0] w_sel_opb;
    logic [REG_SIZE-1:0] r_opa;
    logic [REG_SIZE-1:0] r_opb;
    logic [REG_SIZE-1:0] r_res;
    logic                r_err;
    logic [WD_W-1:0]     r_wd;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [NUM_REQ-1:0]  w_rsp_valid;

    // Requests are only evaluated while idle; anything else waits its turn.
    assign w_grant_en   = (r_state == IDLE) && w_arb_any;
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (req_valid_i),
        .i_grant_en (w_grant_en),
        .o_idx      (w_arb_idx),
        .o_any      (w_arb_any)
    );

    // Operand slice mux for the candidate winner.
    always_comb begin
        w_sel_opa = '0;
        w_sel_opb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_arb_idx == IDX_W'(k)) begin
                w_sel_opa = opa_i[k*REG_SIZE +: REG_SIZE];
                w_sel_opb = opb_i[k*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the accept and response pulses.
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_next = START;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        w_req_ready[k] = (w_arb_idx == IDX_W'(k));
                    end
                end
            end
            START: w_next = ARM;
            // mm_ready_i is deliberately ignored here: it can still be high
            // in the cycle the multiplier samples start.
            ARM:   w_next = WAIT;
            WAIT: begin
                if (mm_ready_i || w_wd_expired) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
                for (int k = 0; k < NUM_REQ; k++) begin
                    w_rsp_valid[k] = (r_gnt == IDX_W'(k));
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch at grant, watchdog, and result/error capture on WAIT exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt <= '0;
            r_opa <= '0;
            r_opb <= '0;
            r_res <= '0;
            r_err <= 1'b0;
            r_wd  <= '0;
        end else begin
            if (w_grant_en) begin
                r_gnt <= w_arb_idx;
                r_opa <= w_sel_opa;
                r_opb <= w_sel_opb;
            end
            if (r_state == ARM) begin
                r_wd <= '0;
            end else if (r_state == WAIT) begin
                r_wd <= r_wd + WD_W'(1);
                // Completion wins over a watchdog expiry in the same cycle.
                if (mm_ready_i) begin
                    r_res <= mm_p_i;
                    r_err <= 1'b0;
                end else if (w_wd_expired) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o = w_req_ready;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_err_o   = r_err;
    assign res_o       = r_res;
    assign busy_o      = (r_state != IDLE);
    assign mm_start_o  = (r_state == START);
    assign mm_opa_o    = r_opa;
    assign mm_opb_o    = r_opb;

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter with a hand-driven multiplier stub.
module tb_mm_arbiter;

    localparam int NR = 3;
    localparam int RS = 384;
    localparam int TO = 63;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*RS-1:0]  opa;
    logic [NR*RS-1:0]  opb;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic [RS-1:0]     res;
    logic              busy;
    logic              mm_start;
    logic [RS-1:0]     mm_opa;
    logic [RS-1:0]     mm_opb;
    logic [RS-1:0]     mm_p;
    logic              mm_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mm_arbiter #(
        .NUM_REQ  (NR),
        .REG_SIZE (RS),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .opa_i       (opa),
        .opb_i       (opb),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .res_o       (res),
        .busy_o      (busy),
        .mm_start_o  (mm_start),
        .mm_opa_o    (mm_opa),
        .mm_opb_o    (mm_opb),
        .mm_p_i      (mm_p),
        .mm_ready_i  (mm_ready)
    );

    task automatic chk(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int seen;
        int expg;
        logic [NR-1:0] oh;

        reset_n   = 1'b0;
        req_valid = '0;
        opa       = '0;
        opb       = '0;
        mm_p      = '0;
        mm_ready  = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_req_ready", RS'(req_ready), 0);
        chk("rst_rsp_valid", RS'(rsp_valid), 0);
        chk("rst_rsp_err",   RS'(rsp_err), 0);
        chk("rst_res",       res, 0);
        chk("rst_mm_opa",    mm_opa, 0);
        chk("rst_mm_opb",    mm_opb, 0);
        chk("rst_mm_start",  RS'(mm_start), 0);
        chk("rst_busy",      RS'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Single request from requester 0: 2 x 3, stub product 6
        opa[0 +: RS] = 2;
        opb[0 +: RS] = 3;
        mm_p = 6;
        req_valid = 3'b001;
        #1;
        chk("single_accept", RS'(req_ready), 3'b001);
        chk("single_no_early_start", RS'(mm_start), 0);
        tick();
        req_valid = '0;
        chk("single_start", RS'(mm_start), 1);
        chk("single_ready_pulse_once", RS'(req_ready), 0);
        chk("single_opa", mm_opa, 2);
        chk("single_opb", mm_opb, 3);
        chk("single_busy", RS'(busy), 1);
        tick();
        chk("single_start_one_cycle", RS'(mm_start), 0);
        tick();
        mm_ready = 1'b1;
        tick();
        chk("single_rsp", RS'(rsp_valid), 3'b001);
        chk("single_err", RS'(rsp_err), 0);
        chk("single_res", res, 6);
        mm_ready = 1'b0;
        tick();
        chk("single_rsp_once", RS'(rsp_valid), 0);
        chk("single_idle", RS'(busy), 0);

        // Ready blanking: ready held high through START and ARM
        opa[RS +: RS] = 5;
        opb[RS +: RS] = 7;
        mm_p = 'hABC;
        req_valid = 3'b010;
        mm_ready = 1'b1;
        #1;
        chk("blank_accept", RS'(req_ready), 3'b010);
        tick();
        req_valid = '0;
        chk("blank_start", RS'(mm_start), 1);
        chk("blank_opa", mm_opa, 5);
        chk("blank_opb", mm_opb, 7);
        tick();
        chk("blank_no_rsp_arm", RS'(rsp_valid), 0);
        tick();
        chk("blank_no_rsp_wait0", RS'(rsp_valid), 0);
        mm_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid != '0) seen++;
        end
        chk("blank_no_early_rsp", RS'(seen), 0);
        mm_ready = 1'b1;
        tick();
        chk("blank_rsp", RS'(rsp_valid), 3'b010);
        chk("blank_res", res, 'hABC);
        chk("blank_err", RS'(rsp_err), 0);
        mm_ready = 1'b0;
        tick();

        // Timeout: multiplier never completes
        opa[2*RS +: RS] = 9;
        opb[2*RS +: RS] = 11;
        mm_p = 'hDEAD;
        req_valid = 3'b100;
        #1;
        chk("to_accept", RS'(req_ready), 3'b100);
        tick();
        req_valid = '0;
        chk("to_opa", mm_opa, 9);
        tick();
        tick();
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", RS'(n), TO + 1);
        chk("to_rsp", RS'(rsp_valid), 3'b100);
        chk("to_err", RS'(rsp_err), 1);
        chk("to_res_held", res, 'hABC);
        tick();

        // Normal request right after a timeout
        mm_p = 6;
        req_valid = 3'b001;
        #1;
        chk("post_to_accept", RS'(req_ready), 3'b001);
        tick();
        req_valid = '0;
        tick();
        tick();
        mm_ready = 1'b1;
        tick();
        chk("post_to_rsp", RS'(rsp_valid), 3'b001);
        chk("post_to_err", RS'(rsp_err), 0);
        chk("post_to_res", res, 6);
        mm_ready = 1'b0;
        tick();

        // Ready and watchdog expiry in the same cycle
        mm_p = 'h1234;
        req_valid = 3'b010;
        #1;
        chk("tie_accept", RS'(req_ready), 3'b010);
        tick();
        req_valid = '0;
        tick();
        tick();
        repeat (TO) tick();
        chk("tie_no_rsp_before", RS'(rsp_valid), 0);
        mm_ready = 1'b1;
        tick();
        chk("tie_rsp", RS'(rsp_valid), 3'b010);
        chk("tie_err", RS'(rsp_err), 0);
        chk("tie_res", res, 'h1234);
        mm_ready = 1'b0;
        tick();

        // Asynchronous reset while waiting
        mm_p = 'h55;
        req_valid = 3'b001;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        repeat (3) tick();
        chk("rw_busy_before", RS'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_busy", RS'(busy), 0);
        chk("rw_start", RS'(mm_start), 0);
        chk("rw_rsp", RS'(rsp_valid), 0);
        chk("rw_err", RS'(rsp_err), 0);
        chk("rw_res", res, 0);
        chk("rw_opa", mm_opa, 0);
        chk("rw_opb", mm_opb, 0);
        tick();
        reset_n = 1'b1;
        mm_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid != '0 || busy) seen++;
        end
        chk("rw_no_rsp_after", RS'(seen), 0);
        mm_ready = 1'b0;

        // Contention: all requesters valid, grants rotate from 0
        for (int k = 0; k < NR; k++) begin
            opa[k*RS +: RS] = RS'(16 + k);
            opb[k*RS +: RS] = RS'(32 + k);
        end
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            expg = i % 3;
            oh = 3'b001 << expg;
            mm_p = RS'(100 + i);
            #1;
            chk("cont_accept", RS'(req_ready), RS'(oh));
            tick();
            chk("cont_start", RS'(mm_start), 1);
            chk("cont_opa", mm_opa, RS'(16 + expg));
            chk("cont_opb", mm_opb, RS'(32 + expg));
            tick();
            tick();
            mm_ready = 1'b1;
            tick();
            chk("cont_rsp", RS'(rsp_valid), RS'(oh));
            chk("cont_res", res, RS'(100 + i));
            chk("cont_no_ready_in_rsp", RS'(req_ready), 0);
            mm_ready = 1'b0;
            tick();
            chk("cont_rsp_once", RS'(rsp_valid), 0);
        end
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
